// File: rtl/mario_pkg.sv
// Shared game constants: tile geometry, level size and camera FSM encoding.
package mario_pkg;

   localparam int unsigned TILE_SHIFT   = 4;
   localparam int unsigned SCREEN_TILES = 80;
   localparam int unsigned LEVEL_TILES  = 128;
   localparam int unsigned MAX_CAM_PX   = (LEVEL_TILES - SCREEN_TILES) << TILE_SHIFT;

   typedef enum logic [1:0] {
      CAM_IDLE,
      CAM_CALC,
      CAM_STEP,
      CAM_COMMIT
   } cam_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a VGA sync line and flags the first cycle it enters its active level.
module sync_edge_det #(
   parameter logic VS_POL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_in,
   output logic edge_pulse
);

   logic sync_q;
   logic sync_d;

   // Next value of the delayed sync sample.
   always_comb begin
      sync_d = sync_in;
   end

   // Delayed sync sample; resets to the active level so a reset release
   // during sync does not look like a fresh edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= VS_POL;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign edge_pulse = (sync_in == VS_POL) && (sync_q != VS_POL);

endmodule

// File: rtl/camera_scroll.sv
// Rightward-only camera with dead zone and per-frame speed limit; commits
// the new position once per frame, just after the vertical-sync edge.
module camera_scroll #(
   parameter int unsigned TILE_SHIFT   = mario_pkg::TILE_SHIFT,
   parameter int unsigned SCREEN_TILES = mario_pkg::SCREEN_TILES,
   parameter int unsigned LEVEL_TILES  = mario_pkg::LEVEL_TILES,
   parameter int unsigned DEAD_ZONE_PX = 640,
   parameter int unsigned MAX_STEP_PX  = 4,
   parameter logic        VS_POL       = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vs,
   input  logic [10:0] mario_x,
   input  logic        restart,
   input  logic        freeze,
   output logic [6:0]  view,
   output logic [3:0]  fine,
   output logic [10:0] left_wall,
   output logic        scrolled
);

   import mario_pkg::*;

   localparam int unsigned CAM_LIMIT = (LEVEL_TILES - SCREEN_TILES) << TILE_SHIFT;
   localparam logic [10:0] DZ_PX     = 11'(DEAD_ZONE_PX);
   localparam logic [10:0] STEP_PX   = 11'(MAX_STEP_PX);
   localparam logic [11:0] LIMIT_PX  = 12'(CAM_LIMIT);
   localparam logic [10:0] FINE_MASK = 11'((1 << TILE_SHIFT) - 1);

   cam_state_e  state_q, state_d;
   logic [10:0] cam_x_q, cam_x_d;
   logic [10:0] want_q, want_d;
   logic [10:0] nxt_q, nxt_d;
   logic        scrolled_q, scrolled_d;

   logic        frame_edge;
   logic [10:0] scr;
   logic [10:0] step;
   logic [11:0] sum;

   sync_edge_det #(
      .VS_POL (VS_POL)
   ) u_vs_edge (
      .clk        (clk),
      .rst        (rst),
      .sync_in    (vs),
      .edge_pulse (frame_edge)
   );

   // Camera FSM state and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CAM_IDLE;
         cam_x_q    <= '0;
         want_q     <= '0;
         nxt_q      <= '0;
         scrolled_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cam_x_q    <= cam_x_d;
         want_q     <= want_d;
         nxt_q      <= nxt_d;
         scrolled_q <= scrolled_d;
      end
   end

   // Next-state and datapath: dead-zone push, speed limit, level clamp;
   // restart overrides everything and drops any pending commit.
   always_comb begin
      state_d    = state_q;
      cam_x_d    = cam_x_q;
      want_d     = want_q;
      nxt_d      = nxt_q;
      scrolled_d = 1'b0;

      scr  = (mario_x > cam_x_q) ? (mario_x - cam_x_q) : '0;
      step = (want_q > STEP_PX) ? STEP_PX : want_q;
      sum  = {1'b0, cam_x_q} + {1'b0, step};

      if (restart) begin
         state_d = CAM_IDLE;
         cam_x_d = '0;
      end else begin
         unique case (state_q)
            CAM_IDLE: begin
               if (frame_edge && !freeze) begin
                  state_d = CAM_CALC;
               end
            end
            CAM_CALC: begin
               want_d  = (scr > DZ_PX) ? (scr - DZ_PX) : '0;
               state_d = CAM_STEP;
            end
            CAM_STEP: begin
               nxt_d   = (sum > LIMIT_PX) ? 11'(LIMIT_PX) : sum[10:0];
               state_d = CAM_COMMIT;
            end
            CAM_COMMIT: begin
               cam_x_d    = nxt_q;
               scrolled_d = (nxt_q != cam_x_q);
               state_d    = CAM_IDLE;
            end
            default: begin
               state_d = CAM_IDLE;
            end
         endcase
      end
   end

   assign view      = 7'(cam_x_q >> TILE_SHIFT);
   assign fine      = 4'(cam_x_q & FINE_MASK);
   assign left_wall = cam_x_q;
   assign scrolled  = scrolled_q;

endmodule
